// File: rtl/door_pkg.sv
// Shared definitions for the door access sequencer: state codes,
// default timing parameters and small helpers.
package door_pkg;

  typedef enum logic [2:0] {
    ST_RELOCK  = 3'd0,
    ST_ARMED   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } seq_state_t;

  localparam int DEF_MAX_FAIL       = 3;
  localparam int DEF_UNLOCK_CYCLES  = 16;
  localparam int DEF_LOCKOUT_CYCLES = 64;
  localparam int DEF_ENTRY_TIMEOUT  = 32;

  localparam int DWELL_W = 8;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable 8-bit down counter; expired marks the last cycle of a dwell.
module dwell_timer
  import door_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expired,
  output logic [DWELL_W-1:0] count
);

  // Holds at zero once drained so an unused dwell never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == DWELL_W'(1));

endmodule

// File: rtl/door_access_sequencer.sv
// Sequences a keypad lock controller: gates digits, opens the door on a
// correct code, counts wrong codes and raises a timed alarm lockout.
module door_access_sequencer
  import door_pkg::*;
#(
  parameter int MAX_FAIL       = DEF_MAX_FAIL,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int ENTRY_TIMEOUT  = DEF_ENTRY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       lock_out,
  input  logic       lock_err,
  output logic       lock_enter,
  output logic       lock_rst,
  output logic       door_open,
  output logic       alarm,
  output logic [1:0] fail_cnt,
  output logic [2:0] seq_state
);

  seq_state_t         state;
  seq_state_t         nxt;
  logic               entry_started;
  logic               dwell_load;
  logic [DWELL_W-1:0] dwell_value;
  logic [DWELL_W-1:0] dwell_count;
  logic               dwell_expired;

  dwell_timer u_dwell (
    .clk     (clk),
    .rst     (rst),
    .load    (dwell_load),
    .value   (dwell_value),
    .expired (dwell_expired),
    .count   (dwell_count)
  );

  // Lock controller flags are only meaningful while ARMED.
  always_comb begin
    nxt = state;
    case (state)
      ST_RELOCK:  if (dwell_expired) nxt = ST_ARMED;
      ST_ARMED: begin
        if (lock_out)      nxt = ST_OPEN;
        else if (lock_err) nxt = ST_FAIL;
        else if (entry_started && !enter && dwell_expired) nxt = ST_RELOCK;
      end
      ST_OPEN:    if (dwell_expired) nxt = ST_RELOCK;
      ST_FAIL:    nxt = (fail_cnt == 2'(MAX_FAIL)) ? ST_LOCKOUT : ST_RELOCK;
      ST_LOCKOUT: if (dwell_expired) nxt = ST_RELOCK;
      default:    nxt = ST_RELOCK;
    endcase
  end

  // A drained dwell in RELOCK only happens straight after reset; loading 1
  // there gives the extra lock_rst cycle before arming.
  always_comb begin
    dwell_load = (nxt != state)
              || (state == ST_ARMED && enter)
              || (state == ST_RELOCK && dwell_count == '0);
    case (nxt)
      ST_ARMED:   dwell_value = DWELL_W'(ENTRY_TIMEOUT);
      ST_OPEN:    dwell_value = DWELL_W'(UNLOCK_CYCLES);
      ST_LOCKOUT: dwell_value = DWELL_W'(LOCKOUT_CYCLES);
      default:    dwell_value = DWELL_W'(1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RELOCK;
      lock_rst      <= 1'b1;
      door_open     <= 1'b0;
      alarm         <= 1'b0;
      fail_cnt      <= 2'd0;
      entry_started <= 1'b0;
    end else begin
      state     <= nxt;
      lock_rst  <= (nxt == ST_RELOCK);
      door_open <= (nxt == ST_OPEN);
      alarm     <= (nxt == ST_LOCKOUT);
      entry_started <= (state == ST_ARMED && nxt == ST_ARMED) ? (entry_started | enter) : 1'b0;
      if (state == ST_ARMED && nxt == ST_FAIL) begin
        fail_cnt <= sat_inc2(fail_cnt);
      end else if (state == ST_ARMED && nxt == ST_OPEN) begin
        fail_cnt <= 2'd0;
      end else if (state == ST_LOCKOUT && nxt == ST_RELOCK) begin
        fail_cnt <= 2'd0;
      end
    end
  end

  assign lock_enter = enter && (state == ST_ARMED);
  assign seq_state  = state;

endmodule

// File: tb/tb_door_access_sequencer.sv
// Bench for door_access_sequencer: directed scenarios plus random traffic
// compared cycle by cycle against a rule-level model of the door sequencer.
module tb_door_access_sequencer;

  localparam int MAX_FAIL       = 3;
  localparam int UNLOCK_CYCLES  = 16;
  localparam int LOCKOUT_CYCLES = 64;
  localparam int ENTRY_TIMEOUT  = 32;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic       enter;
  logic       lock_out;
  logic       lock_err;
  logic       lock_enter;
  logic       lock_rst;
  logic       door_open;
  logic       alarm;
  logic [1:0] fail_cnt;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  door_access_sequencer #(
    .MAX_FAIL       (MAX_FAIL),
    .UNLOCK_CYCLES  (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .ENTRY_TIMEOUT  (ENTRY_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enter      (enter),
    .lock_out   (lock_out),
    .lock_err   (lock_err),
    .lock_enter (lock_enter),
    .lock_rst   (lock_rst),
    .door_open  (door_open),
    .alarm      (alarm),
    .fail_cnt   (fail_cnt),
    .seq_state  (seq_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 relock, 1 armed, 2 open, 3 fail, 4 lockout.
  int m_st;
  int m_hold;
  int m_el;
  int m_idle;
  int m_fail;

  function automatic void model_reset();
    m_st   = 0;
    m_hold = 1;
    m_el   = 0;
    m_idle = -1;
    m_fail = 0;
  endfunction

  function automatic logic [W-1:0] model_outputs();
    return {m_st == 0, m_st == 2, m_st == 4, 2'(m_fail), 3'(m_st)};
  endfunction

  function automatic void model_step(input logic e, input logic o, input logic r);
    case (m_st)
      0: begin
        if (m_hold != 0) m_hold = 0;
        else begin m_st = 1; m_idle = -1; end
      end
      1: begin
        if (o) begin
          m_st = 2; m_el = 0; m_fail = 0;
        end else if (r) begin
          m_st = 3; m_fail = (m_fail < 3) ? m_fail + 1 : 3;
        end else if (e) begin
          m_idle = 0;
        end else if (m_idle >= 0) begin
          m_idle++;
          if (m_idle == ENTRY_TIMEOUT) m_st = 0;
        end
      end
      2: begin
        m_el++;
        if (m_el == UNLOCK_CYCLES) m_st = 0;
      end
      3: begin
        if (m_fail == MAX_FAIL) begin m_st = 4; m_el = 0; end
        else m_st = 0;
      end
      default: begin
        m_el++;
        if (m_el == LOCKOUT_CYCLES) begin m_st = 0; m_fail = 0; end
      end
    endcase
    exp_q.push_back(model_outputs());
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string pfx, input logic [W-1:0] exp);
    check({pfx, "lock_rst"},  int'(lock_rst),  int'(exp[7]));
    check({pfx, "door_open"}, int'(door_open), int'(exp[6]));
    check({pfx, "alarm"},     int'(alarm),     int'(exp[5]));
    check({pfx, "fail_cnt"},  int'(fail_cnt),  int'(exp[4:3]));
    check({pfx, "seq_state"}, int'(seq_state), int'(exp[2:0]));
  endtask

  // Driver: starts and ends 1 time unit after a rising edge.
  task automatic step(input logic e, input logic o, input logic r);
    logic [W-1:0] exp;
    enter = e; lock_out = o; lock_err = r;
    #4;
    check("lock_enter", int'(lock_enter), int'(e && m_st == 1));
    @(posedge clk);
    model_step(e, o, r);
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      compare_outputs("", exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wrong_code();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic good_code();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse landing mid-cycle.
  task automatic pulse_reset();
    enter = 1'b0; lock_out = 1'b0; lock_err = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    compare_outputs("async_", model_outputs());
    @(posedge clk);
    #1 rst = 1'b0;
    compare_outputs("held_", model_outputs());
  endtask

  initial begin
    rst = 1'b1; enter = 1'b0; lock_out = 1'b0; lock_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs("reset_", model_outputs());
    rst = 1'b0;

    // Reset release: one more lock_rst edge, then armed.
    idle(3);

    // Correct code opens the door for the unlock window.
    good_code();
    idle(UNLOCK_CYCLES + 4);

    // Three wrong codes lead to lockout; digits during lockout are blocked.
    for (int k = 0; k < 3; k++) begin
      wrong_code();
      idle(3);
    end
    for (int i = 0; i < LOCKOUT_CYCLES + 4; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);

    // Two wrong codes then a correct one clears the count.
    wrong_code(); idle(3);
    wrong_code(); idle(3);
    good_code();
    idle(UNLOCK_CYCLES + 3);

    // Digit-entry timeout, then a long idle with no digit.
    wrong_code(); idle(3);
    step(1'b1, 1'b0, 1'b0);
    idle(ENTRY_TIMEOUT + 4);
    idle(100);

    // Both flags together opens; reset lands in the fifth open cycle.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    idle(4);
    pulse_reset();
    idle(4);

    // Reset during lockout.
    for (int k = 0; k < 3; k++) begin wrong_code(); idle(3); end
    idle(10);
    pulse_reset();
    idle(4);

    // Random traffic with sparse or dense digits and occasional resets.
    for (int s = 0; s < 40; s++) begin
      int p;
      int len;
      p   = ($urandom_range(0, 1) == 0) ? 5 : 30;
      len = $urandom_range(40, 120);
      for (int i = 0; i < len; i++) begin
        step(1'($urandom_range(0, 99) < p),
             1'($urandom_range(0, 99) < 2),
             1'($urandom_range(0, 99) < 5));
      end
      if ($urandom_range(0, 9) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
